// File: rtl/uart_tx_if.sv
// Byte-stream valid/ready handshake between an upstream producer and uart_tx.
interface uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input  tx_ready);
  modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB-first, optional parity, 1 or 2 stop bits.
// Parity is compiled in with `define UART_TX_PARITY_EN.
module uart_tx #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic     clk_i,
  input  logic     rst_i,
  uart_tx_if.slave tx_if,
  output logic     tx_o,
  output logic     busy_o
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CNT_W        = (CLKS_PER_BIT >= 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic STOP_LAST = (STOP_BITS == 2);

  if (CLKS_PER_BIT < 2) begin : g_chk_cpb
    $error("uart_tx: CLK_FREQ / BAUD_RATE must be at least 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_chk_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD > 1) begin : g_chk_par
    $error("uart_tx: PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       sh_q, sh_d;
  logic             stop_q, stop_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             bit_end;
`ifdef UART_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  assign tx_if.tx_ready = (state_q == S_IDLE) && !rst_i;
  assign tx_o           = tx_q;
  assign busy_o         = busy_q;
  assign bit_end        = (cnt_q == CNT_LAST);

  // State and datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      stop_q  <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      stop_q  <= stop_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state logic; the line value is decoded from the next state so tx_o is a flop
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    sh_d    = sh_q;
    stop_d  = stop_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (tx_if.tx_valid && tx_if.tx_ready) begin
          state_d = S_START;
          sh_d    = tx_if.tx_data;
          idx_d   = 3'd0;
`ifdef UART_TX_PARITY_EN
          par_d   = (^tx_if.tx_data) ^ 1'(PARITY_ODD);
`endif
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          cnt_d   = '0;
          idx_d   = 3'd0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
            stop_d  = 1'b0;
          end else begin
            idx_d = idx_q + 3'd1;
            sh_d  = {1'b0, sh_q[7:1]};
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          cnt_d   = '0;
          stop_d  = 1'b0;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (stop_q == STOP_LAST) begin
            state_d = S_IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = sh_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = par_d;
`endif
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: per-cycle line model pushed to a scoreboard queue.
module tb_uart_tx;

  localparam int unsigned CLK_FREQ  = 1_000_000;
  localparam int unsigned BAUD_RATE = 100_000;
  localparam int unsigned CPB       = CLK_FREQ / BAUD_RATE;
  localparam int unsigned STOP_BITS = 1;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned PBITS = 1;
`else
  localparam int unsigned PBITS = 0;
`endif
  localparam int unsigned FRAME_BITS = 1 + 8 + PBITS + STOP_BITS;
  localparam int unsigned FRAME_CYC  = FRAME_BITS * CPB;

  logic clk = 1'b0;
  logic rst;
  logic tx, busy;
  int   vectors = 0;
  int   miscompares = 0;
  logic exp_q[$];
  logic exp;

  always #5 clk = ~clk;

  uart_tx_if tx_if ();

  uart_tx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .STOP_BITS (STOP_BITS),
    .PARITY_ODD(0)
  ) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .tx_if (tx_if),
    .tx_o  (tx),
    .busy_o(busy)
  );

`ifdef UART_TX_PARITY_EN
  uart_tx_if tx_if_odd ();
  logic tx_odd, busy_odd;

  uart_tx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .STOP_BITS (STOP_BITS),
    .PARITY_ODD(1)
  ) u_dut_odd (
    .clk_i (clk),
    .rst_i (rst),
    .tx_if (tx_if_odd),
    .tx_o  (tx_odd),
    .busy_o(busy_odd)
  );
`endif

  // Expected line level for every cycle of one frame
  task automatic push_frame(input logic [7:0] d, input logic odd);
    logic [10:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
    if (PBITS == 1) f[9] = (^d) ^ odd;
    for (int b = 0; b < int'(FRAME_BITS); b++)
      for (int c = 0; c < int'(CPB); c++)
        exp_q.push_back(f[b]);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tx_if.tx_valid = 1'b1;
    tx_if.tx_data  = 8'hA5;
    repeat (5) begin
      @(negedge clk);
      vectors++;
      if (tx !== 1'b1 || tx_if.tx_ready !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_hold tx=%b ready=%b busy=%b, required 1/0/0", tx, tx_if.tx_ready, busy);
      end
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (tx_if.tx_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release ready=%b busy=%b, required 1/0", tx_if.tx_ready, busy);
    end
  endtask

  task automatic test_single_byte(input logic [7:0] d);
    push_frame(d, 1'b0);
    tx_if.tx_valid = 1'b1;
    tx_if.tx_data  = d;
    for (int k = 0; k < int'(FRAME_CYC); k++) begin
      @(negedge clk);
      exp = exp_q.pop_front();
      vectors++;
      if (tx !== exp || busy !== 1'b1 || tx_if.tx_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL single_%h k=%0d tx=%b busy=%b ready=%b, required %b/1/0",
                 d, k, tx, busy, tx_if.tx_ready, exp);
      end
      if (k == 0) tx_if.tx_valid = 1'b0;
    end
    @(negedge clk);
    vectors++;
    if (tx !== 1'b1 || busy !== 1'b0 || tx_if.tx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL single_%h_idle tx=%b busy=%b ready=%b, required 1/0/1", d, tx, busy, tx_if.tx_ready);
    end
  endtask

  task automatic test_back_to_back();
    push_frame(8'h00, 1'b0);
    push_frame(8'hFF, 1'b0);
    tx_if.tx_valid = 1'b1;
    tx_if.tx_data  = 8'h00;
    for (int fr = 0; fr < 2; fr++) begin
      for (int k = 0; k < int'(FRAME_CYC); k++) begin
        @(negedge clk);
        exp = exp_q.pop_front();
        vectors++;
        if (tx !== exp || busy !== 1'b1 || tx_if.tx_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_f%0d k=%0d tx=%b busy=%b ready=%b, required %b/1/0",
                   fr, k, tx, busy, tx_if.tx_ready, exp);
        end
        if (fr == 0 && k == 5) tx_if.tx_data = 8'hFF;
        if (fr == 1 && k == 0) tx_if.tx_valid = 1'b0;
      end
      @(negedge clk);
      vectors++;
      if (tx !== 1'b1 || busy !== 1'b0 || tx_if.tx_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_gap_f%0d tx=%b busy=%b ready=%b, required 1/0/1", fr, tx, busy, tx_if.tx_ready);
      end
    end
  endtask

  task automatic test_data_change();
    push_frame(8'h3C, 1'b0);
    tx_if.tx_valid = 1'b1;
    tx_if.tx_data  = 8'h3C;
    for (int k = 0; k < int'(FRAME_CYC); k++) begin
      @(negedge clk);
      exp = exp_q.pop_front();
      vectors++;
      if (tx !== exp || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL data_change k=%0d tx=%b busy=%b, required %b/1", k, tx, busy, exp);
      end
      if (k == 0) tx_if.tx_valid = 1'b0;
      if (k == int'(3 * CPB)) begin
        tx_if.tx_data  = 8'hC3;
        tx_if.tx_valid = 1'b1;
      end
    end
    tx_if.tx_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL data_change_idle tx=%b busy=%b, required 1/0", tx, busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    push_frame(8'h55, 1'b0);
    tx_if.tx_valid = 1'b1;
    tx_if.tx_data  = 8'h55;
    for (int k = 0; k <= int'(5 * CPB + 3); k++) begin
      @(negedge clk);
      exp = exp_q.pop_front();
      vectors++;
      if (tx !== exp) begin
        miscompares++;
        $display("FAIL reset_mid_pre k=%0d tx=%b, required %b", k, tx, exp);
      end
      if (k == 0) tx_if.tx_valid = 1'b0;
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (tx !== 1'b1 || busy !== 1'b0 || tx_if.tx_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_async tx=%b busy=%b ready=%b, required 1/0/0", tx, busy, tx_if.tx_ready);
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_single_byte(8'h0F);
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity_even();
    int busy_cnt;
    busy_cnt = 0;
    push_frame(8'h07, 1'b0);
    tx_if.tx_valid = 1'b1;
    tx_if.tx_data  = 8'h07;
    for (int k = 0; k < int'(FRAME_CYC) + 3; k++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
      if (k < int'(FRAME_CYC)) begin
        exp = exp_q.pop_front();
        vectors++;
        if (tx !== exp) begin
          miscompares++;
          $display("FAIL parity_even k=%0d tx=%b, required %b", k, tx, exp);
        end
      end
      if (k == int'(9 * CPB + 5)) begin
        vectors++;
        if (tx !== 1'b1) begin
          miscompares++;
          $display("FAIL parity_even_bit tx=%b, required 1", tx);
        end
      end
      if (k == 0) tx_if.tx_valid = 1'b0;
    end
    vectors++;
    if (busy_cnt != 110) begin
      miscompares++;
      $display("FAIL parity_frame_len busy_cycles=%0d, required 110", busy_cnt);
    end
  endtask

  task automatic test_parity_odd();
    push_frame(8'h07, 1'b1);
    tx_if_odd.tx_valid = 1'b1;
    tx_if_odd.tx_data  = 8'h07;
    for (int k = 0; k < int'(FRAME_CYC); k++) begin
      @(negedge clk);
      exp = exp_q.pop_front();
      vectors++;
      if (tx_odd !== exp || busy_odd !== 1'b1) begin
        miscompares++;
        $display("FAIL parity_odd k=%0d tx=%b busy=%b, required %b/1", k, tx_odd, busy_odd, exp);
      end
      if (k == int'(9 * CPB + 5)) begin
        vectors++;
        if (tx_odd !== 1'b0) begin
          miscompares++;
          $display("FAIL parity_odd_bit tx=%b, required 0", tx_odd);
        end
      end
      if (k == 0) tx_if_odd.tx_valid = 1'b0;
    end
    @(negedge clk);
    vectors++;
    if (tx_odd !== 1'b1 || busy_odd !== 1'b0) begin
      miscompares++;
      $display("FAIL parity_odd_idle tx=%b busy=%b, required 1/0", tx_odd, busy_odd);
    end
  endtask
`endif

  initial begin
    #200_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
`ifdef UART_TX_PARITY_EN
    tx_if_odd.tx_valid = 1'b0;
    tx_if_odd.tx_data  = 8'h00;
`endif
    test_reset();
    test_single_byte(8'hA5);
    test_back_to_back();
    test_data_change();
    test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
    test_parity_even();
    test_parity_odd();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
